// File: rtl/mdu.sv
// Multiply/divide unit owning the architectural HI/LO pair: multi-cycle MULT/MULTU,
// 32-cycle radix-2 restoring DIV/DIVU, and single-cycle MTHI/MTLO writes.
module mdu #(
    parameter int unsigned MULT_LAT = 5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Start,
    input  logic [2:0]  MDOp,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic        Busy
);

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        DIV
    } state_t;

    typedef enum logic [2:0] {
        OP_MULT  = 3'd0,
        OP_MULTU = 3'd1,
        OP_DIV   = 3'd2,
        OP_DIVU  = 3'd3,
        OP_MTHI  = 3'd4,
        OP_MTLO  = 3'd5
    } mdop_t;

    state_t      state, state_nxt;
    logic [4:0]  cnt, cnt_nxt;
    logic [31:0] op_a, op_a_nxt;
    logic [31:0] op_b, op_b_nxt;
    logic        op_signed, op_signed_nxt;
    logic [31:0] rem, rem_nxt;
    logic [31:0] quo, quo_nxt;
    logic [31:0] hi_nxt, lo_nxt;
    logic        busy_nxt;

    // Low 64 bits of the extended operands' product equal the 32x32 result
    // for both signed and unsigned interpretation.
    logic [63:0] ext_a, ext_b, product;
    assign ext_a   = {{32{op_signed & op_a[31]}}, op_a};
    assign ext_b   = {{32{op_signed & op_b[31]}}, op_b};
    assign product = ext_a * ext_b;

    // Restoring divide step on magnitudes; quo doubles as the dividend shifter.
    logic [31:0] div_mag;
    logic [32:0] shifted, trial;
    logic        fits;
    logic [31:0] step_rem, step_quo;
    logic        neg_q, neg_r;
    logic [31:0] q_fix, r_fix;

    assign div_mag  = (op_signed && op_b[31]) ? (~op_b + 32'd1) : op_b;
    assign shifted  = {rem, quo[31]};
    assign trial    = shifted - {1'b0, div_mag};
    assign fits     = (shifted >= {1'b0, div_mag});
    assign step_rem = fits ? trial[31:0] : shifted[31:0];
    assign step_quo = {quo[30:0], fits};
    assign neg_q    = op_signed & (op_a[31] ^ op_b[31]);
    assign neg_r    = op_signed & op_a[31];
    assign q_fix    = neg_q ? (~step_quo + 32'd1) : step_quo;
    assign r_fix    = neg_r ? (~step_rem + 32'd1) : step_rem;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            op_a      <= '0;
            op_b      <= '0;
            op_signed <= 1'b0;
            rem       <= '0;
            quo       <= '0;
            HI        <= '0;
            LO        <= '0;
            Busy      <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            op_a      <= op_a_nxt;
            op_b      <= op_b_nxt;
            op_signed <= op_signed_nxt;
            rem       <= rem_nxt;
            quo       <= quo_nxt;
            HI        <= hi_nxt;
            LO        <= lo_nxt;
            Busy      <= busy_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        op_a_nxt      = op_a;
        op_b_nxt      = op_b;
        op_signed_nxt = op_signed;
        rem_nxt       = rem;
        quo_nxt       = quo;
        hi_nxt        = HI;
        lo_nxt        = LO;
        busy_nxt      = Busy;

        case (state)
            IDLE: begin
                if (Start) begin
                    case (MDOp)
                        OP_MULT, OP_MULTU: begin
                            state_nxt     = MUL;
                            busy_nxt      = 1'b1;
                            cnt_nxt       = 5'(MULT_LAT - 1);
                            op_a_nxt      = A;
                            op_b_nxt      = B;
                            op_signed_nxt = (MDOp == OP_MULT);
                        end
                        OP_DIV, OP_DIVU: begin
                            state_nxt     = DIV;
                            busy_nxt      = 1'b1;
                            cnt_nxt       = 5'd31;
                            op_a_nxt      = A;
                            op_b_nxt      = B;
                            op_signed_nxt = (MDOp == OP_DIV);
                            rem_nxt       = '0;
                            quo_nxt       = ((MDOp == OP_DIV) && A[31]) ? (~A + 32'd1) : A;
                        end
                        OP_MTHI: hi_nxt = A;
                        OP_MTLO: lo_nxt = A;
                        default: ;
                    endcase
                end
            end

            MUL: begin
                if (cnt == '0) begin
                    {hi_nxt, lo_nxt} = product;
                    state_nxt        = IDLE;
                    busy_nxt         = 1'b0;
                end else begin
                    cnt_nxt = cnt - 5'd1;
                end
            end

            DIV: begin
                rem_nxt = step_rem;
                quo_nxt = step_quo;
                if (cnt == '0) begin
                    // The last quotient bit is folded straight into HI/LO here.
                    if (op_b == '0) begin
                        lo_nxt = '1;
                        hi_nxt = op_a;
                    end else begin
                        lo_nxt = q_fix;
                        hi_nxt = r_fix;
                    end
                    state_nxt = IDLE;
                    busy_nxt  = 1'b0;
                end else begin
                    cnt_nxt = cnt - 5'd1;
                end
            end

            default: begin
                state_nxt = IDLE;
                busy_nxt  = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_mdu.sv
// Self-checking bench for mdu: directed scenarios plus randomized ops against an
// arithmetic reference model of HI/LO and Busy duration.
module tb_mdu;

    localparam int unsigned MULT_LAT = 5;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        Start = 1'b0;
    logic [2:0]  MDOp = '0;
    logic [31:0] A = '0;
    logic [31:0] B = '0;
    logic [31:0] HI, LO;
    logic        Busy;

    int checks = 0;
    int errors = 0;
    logic [31:0] mdl_hi = '0;
    logic [31:0] mdl_lo = '0;

    always #5 clk = ~clk;

    mdu #(.MULT_LAT(MULT_LAT)) dut (
        .clk   (clk),
        .reset (reset),
        .Start (Start),
        .MDOp  (MDOp),
        .A     (A),
        .B     (B),
        .HI    (HI),
        .LO    (LO),
        .Busy  (Busy)
    );

    function automatic int exp_busy(input logic [2:0] op);
        if (op == 3'd0 || op == 3'd1) return int'(MULT_LAT);
        if (op == 3'd2 || op == 3'd3) return 32;
        return 0;
    endfunction

    function automatic void model_update(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint     sa, sb, q, r;
        logic [63:0] up;
        case (op)
            3'd0: begin
                q = longint'($signed(a)) * longint'($signed(b));
                {mdl_hi, mdl_lo} = q;
            end
            3'd1: begin
                up = {32'd0, a} * {32'd0, b};
                {mdl_hi, mdl_lo} = up;
            end
            3'd2: begin
                if (b == 32'd0) begin
                    mdl_lo = 32'hFFFF_FFFF;
                    mdl_hi = a;
                end else begin
                    sa = longint'($signed(a));
                    sb = longint'($signed(b));
                    q  = sa / sb;
                    r  = sa % sb;
                    mdl_lo = q[31:0];
                    mdl_hi = r[31:0];
                end
            end
            3'd3: begin
                if (b == 32'd0) begin
                    mdl_lo = 32'hFFFF_FFFF;
                    mdl_hi = a;
                end else begin
                    mdl_lo = a / b;
                    mdl_hi = a % b;
                end
            end
            3'd4: mdl_hi = a;
            3'd5: mdl_lo = a;
            default: ;
        endcase
    endfunction

    // Entered just after a negedge; issues the op, then counts Busy cycles while
    // injecting junk Start/operands that must be ignored. Leaves just after a negedge.
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, output int n);
        Start = 1'b1;
        MDOp  = op;
        A     = a;
        B     = b;
        model_update(op, a, b);
        @(negedge clk);
        Start = 1'b0;
        n = 0;
        while (Busy === 1'b1 && n < 100) begin
            n++;
            A     = $urandom;
            B     = $urandom;
            MDOp  = 3'($urandom_range(0, 7));
            Start = 1'($urandom_range(0, 1));
            @(negedge clk);
        end
        Start = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks += 3;
        if (Busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", Busy); end
        if (HI !== 32'd0) begin errors++; $display("FAIL reset_hi: got %h expected 00000000", HI); end
        if (LO !== 32'd0) begin errors++; $display("FAIL reset_lo: got %h expected 00000000", LO); end
        reset = 1'b0;
    endtask

    task automatic test_mult();
        int n;
        run_op(3'd0, 32'hFFFF_FFFE, 32'd3, n);
        checks += 3;
        if (n != 5) begin errors++; $display("FAIL mult_busy: got %0d expected 5", n); end
        if (HI !== 32'hFFFF_FFFF) begin errors++; $display("FAIL mult_hi: got %h expected ffffffff", HI); end
        if (LO !== 32'hFFFF_FFFA) begin errors++; $display("FAIL mult_lo: got %h expected fffffffa", LO); end
        run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, n);
        checks += 3;
        if (n != 5) begin errors++; $display("FAIL multu_busy: got %0d expected 5", n); end
        if (HI !== 32'hFFFF_FFFE) begin errors++; $display("FAIL multu_hi: got %h expected fffffffe", HI); end
        if (LO !== 32'h0000_0001) begin errors++; $display("FAIL multu_lo: got %h expected 00000001", LO); end
    endtask

    task automatic test_div();
        int n;
        run_op(3'd2, -32'sd7, 32'd2, n);
        checks += 3;
        if (n != 32) begin errors++; $display("FAIL div_busy: got %0d expected 32", n); end
        if (LO !== 32'hFFFF_FFFD) begin errors++; $display("FAIL div_lo: got %h expected fffffffd", LO); end
        if (HI !== 32'hFFFF_FFFF) begin errors++; $display("FAIL div_hi: got %h expected ffffffff", HI); end
        run_op(3'd3, 32'd7, 32'd0, n);
        checks += 3;
        if (n != 32) begin errors++; $display("FAIL divz_busy: got %0d expected 32", n); end
        if (LO !== 32'hFFFF_FFFF) begin errors++; $display("FAIL divz_lo: got %h expected ffffffff", LO); end
        if (HI !== 32'd7) begin errors++; $display("FAIL divz_hi: got %h expected 00000007", HI); end
    endtask

    task automatic test_mt_ignore();
        int n;
        logic [31:0] hi_before;
        hi_before = mdl_hi;
        run_op(3'd5, 32'h1234_5678, 32'hDEAD_BEEF, n);
        checks += 3;
        if (n != 0) begin errors++; $display("FAIL mtlo_busy: got %0d expected 0", n); end
        if (LO !== 32'h1234_5678) begin errors++; $display("FAIL mtlo_lo: got %h expected 12345678", LO); end
        if (HI !== hi_before) begin errors++; $display("FAIL mtlo_hi: got %h expected %h", HI, hi_before); end
        run_op(3'd0, 32'd2, 32'd3, n);
        checks += 3;
        if (n != 5) begin errors++; $display("FAIL mult_ign_busy: got %0d expected 5", n); end
        if (LO !== 32'd6) begin errors++; $display("FAIL mult_ign_lo: got %h expected 00000006", LO); end
        if (HI !== 32'd0) begin errors++; $display("FAIL mult_ign_hi: got %h expected 00000000", HI); end
    endtask

    task automatic test_reset_mid();
        int n;
        Start = 1'b1; MDOp = 3'd2; A = $urandom; B = $urandom;
        @(negedge clk);
        Start = 1'b0;
        repeat (9) @(negedge clk);
        checks += 1;
        if (Busy !== 1'b1) begin errors++; $display("FAIL rstmid_busy_before: got %b expected 1", Busy); end
        #2 reset = 1'b1;
        #1;
        mdl_hi = '0;
        mdl_lo = '0;
        checks += 3;
        if (Busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b expected 0", Busy); end
        if (HI !== 32'd0) begin errors++; $display("FAIL rstmid_hi: got %h expected 00000000", HI); end
        if (LO !== 32'd0) begin errors++; $display("FAIL rstmid_lo: got %h expected 00000000", LO); end
        @(negedge clk);
        reset = 1'b0;
        run_op(3'd3, 32'd100, 32'd7, n);
        checks += 3;
        if (n != 32) begin errors++; $display("FAIL rstmid_divu_busy: got %0d expected 32", n); end
        if (LO !== 32'd14) begin errors++; $display("FAIL rstmid_divu_lo: got %h expected 0000000e", LO); end
        if (HI !== 32'd2) begin errors++; $display("FAIL rstmid_divu_hi: got %h expected 00000002", HI); end
    endtask

    task automatic test_back_to_back();
        int n;
        run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, n);
        checks += 3;
        if (n != 32) begin errors++; $display("FAIL ovf_busy: got %0d expected 32", n); end
        if (LO !== 32'h8000_0000) begin errors++; $display("FAIL ovf_lo: got %h expected 80000000", LO); end
        if (HI !== 32'd0) begin errors++; $display("FAIL ovf_hi: got %h expected 00000000", HI); end
        run_op(3'd0, 32'd7, -32'sd3, n);
        checks += 3;
        if (n != 5) begin errors++; $display("FAIL b2b_busy: got %0d expected 5", n); end
        if (HI !== 32'hFFFF_FFFF) begin errors++; $display("FAIL b2b_hi: got %h expected ffffffff", HI); end
        if (LO !== 32'hFFFF_FFEB) begin errors++; $display("FAIL b2b_lo: got %h expected ffffffeb", LO); end
    endtask

    task automatic test_random();
        int n;
        logic [2:0]  op;
        logic [31:0] a, b;
        for (int i = 0; i < 60; i++) begin
            op = 3'($urandom_range(0, 7));
            a  = $urandom;
            b  = $urandom;
            case ($urandom_range(0, 7))
                0: b = 32'd0;
                1: b = 32'($urandom_range(1, 20));
                2: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                3: a = 32'($urandom_range(0, 1000));
                default: ;
            endcase
            run_op(op, a, b, n);
            checks += 3;
            if (n != exp_busy(op)) begin errors++; $display("FAIL rnd_busy op=%0d: got %0d expected %0d", op, n, exp_busy(op)); end
            if (HI !== mdl_hi) begin errors++; $display("FAIL rnd_hi op=%0d a=%h b=%h: got %h expected %h", op, a, b, HI, mdl_hi); end
            if (LO !== mdl_lo) begin errors++; $display("FAIL rnd_lo op=%0d a=%h b=%h: got %h expected %h", op, a, b, LO, mdl_lo); end
        end
    endtask

    initial begin
        test_reset();
        test_mult();
        test_div();
        test_mt_ignore();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mdu.md
MDU -- requirements
Module: mdu

Interface
REQ-001 Parameter MULT_LAT, default 5, SHALL set the cycles Busy stays high for MULT/MULTU; legal range 1..15.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 Start  input  1  one-cycle strobe: the EX-stage instruction is a multiply/divide op.
REQ-005 MDOp  input  3  0=MULT, 1=MULTU, 2=DIV, 3=DIVU, 4=MTHI, 5=MTLO; 6,7 reserved.
REQ-006 A  input  32  rs operand (already forwarded).
REQ-007 B  input  32  rt operand (already forwarded).
REQ-008 HI  output  32  architectural HI register.
REQ-009 LO  output  32  architectural LO register.
REQ-010 Busy  output  1  registered; high while an operation is in flight; the hazard unit uses Start|Busy to stall following MFHI/MFLO/MD instructions.

Function
REQ-011 The block SHALL use the states IDLE, MUL and DIV.
REQ-012 In IDLE with Start=1 and MDOp=MULT/MULTU, the block SHALL latch A and B, enter MUL, and raise Busy for exactly MULT_LAT cycles starting the cycle after the Start edge.
REQ-013 MULT SHALL form the signed 64-bit product and MULTU the unsigned product; {HI,LO} SHALL take the product at the edge that ends the last Busy cycle, and the block SHALL return to IDLE.
REQ-014 In IDLE with Start=1 and MDOp=DIV/DIVU, the block SHALL enter DIV and raise Busy for exactly 32 cycles, running a radix-2 restoring divide with one quotient bit per cycle on operand magnitudes.
REQ-015 DIV SHALL truncate toward zero, the remainder SHALL take the dividend's sign, LO SHALL receive the quotient and HI the remainder at the edge that ends the 32nd Busy cycle.
REQ-016 Divide by zero (B=0) SHALL still take 32 cycles and SHALL set LO=32'hFFFF_FFFF and HI=A, for both DIV and DIVU.
REQ-017 DIV with A=32'h8000_0000 and B=32'hFFFF_FFFF SHALL set LO=32'h8000_0000 and HI=0.
REQ-018 MTHI/MTLO with Start=1 in IDLE SHALL write A into HI/LO at that edge, SHALL not raise Busy, and SHALL leave the other register unchanged.
REQ-019 Start while Busy=1 SHALL be ignored: no state, operand or HI/LO change.
REQ-020 Start with a reserved MDOp SHALL be ignored.
REQ-021 HI and LO SHALL hold their values at all times except at the completion edge (REQ-013, REQ-015, REQ-016) or an MT write (REQ-018); intermediate divide state SHALL never be visible on HI/LO.
REQ-022 Busy SHALL fall in the same cycle that HI/LO first show the new result, so a stalled MFHI/MFLO released that cycle reads the correct value.
REQ-023 Back-to-back operations SHALL be supported: a Start in the first cycle Busy=0 SHALL be accepted.
REQ-024 Operands SHALL be sampled only at the accepting Start edge; later changes on A/B SHALL have no effect.

Reset
REQ-025 While reset=1, asynchronously: state=IDLE, Busy=0, HI=0, LO=0, and all internal counters and partial results cleared.
REQ-026 A reset asserted mid-operation SHALL abort the operation with no HI/LO update.
REQ-027 After reset deasserts, the block SHALL accept a Start on the first rising edge.

Verification
REQ-028 MULT A=32'hFFFF_FFFE (-2), B=3 -> Busy high 5 cycles; then HI=32'hFFFF_FFFF, LO=32'hFFFF_FFFA, Busy=0.
REQ-029 MULTU A=32'hFFFF_FFFF, B=32'hFFFF_FFFF -> after 5 Busy cycles HI=32'hFFFF_FFFE, LO=32'h0000_0001.
REQ-030 DIV A=-7, B=2 -> Busy high 32 cycles; then LO=32'hFFFF_FFFD (-3), HI=32'hFFFF_FFFF (-1); DIVU A=7, B=0 -> LO=32'hFFFF_FFFF, HI=7.
REQ-031 MTLO A=32'h1234_5678 while idle -> LO=32'h1234_5678 next cycle, HI unchanged, Busy stays 0; then MULT Start with A=2, B=3 while Busy -> a second Start is ignored and the result is LO=6 only.
REQ-032 Reset pulse in DIV cycle 10 -> Busy=0 and HI=LO=0 immediately; a DIVU 100/7 started the next edge -> LO=14, HI=2 after 32 cycles.
REQ-033 DIV 32'h8000_0000 / 32'hFFFF_FFFF -> LO=32'h8000_0000, HI=0; a MULT Start in the first Busy=0 cycle -> accepted.
